// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter: FSM states,
// requester IDs and default bus widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the CPU and loader requesters.
// On a tie the requester that did not win last time takes the port.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CPU;
        if (req0 && req1)
            winner = ~last_owner;
        else if (req1)
            winner = REQ_LDR;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: IDLE/ACCESS/RESP FSM with registered outputs.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating tie-break; default is CPU priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t state;
    logic       owner;
    logic       last_owner;
    logic       winner;
    logic       pick_valid;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Pinning last_owner to the loader makes every tie resolve to the CPU.
    assign last_owner = REQ_LDR;
`endif

    mem_arb_pick u_pick (
        .req0      (req0),
        .req1      (req1),
        .last_owner(last_owner),
        .winner    (winner),
        .valid     (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= REQ_CPU;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= REQ_LDR;
`endif
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= winner;
                        gnt0      <= (winner == REQ_CPU);
                        gnt1      <= (winner == REQ_LDR);
                        mem_en    <= 1'b1;
                        mem_we    <= (winner == REQ_LDR) ? we1    : we0;
                        mem_addr  <= (winner == REQ_LDR) ? addr1  : addr0;
                        mem_wdata <= (winner == REQ_LDR) ? wdata1 : wdata0;
                        state     <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner <= winner;
`endif
                    end
                end
                ACCESS: begin
                    // Command stays latched on the memory bus until completion.
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!mem_we)
                            rdata <= mem_rdata;
                        state <= RESP;
                    end
                end
                RESP: begin
                    done0 <= (owner == REQ_CPU);
                    done1 <= (owner == REQ_LDR);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
